// File: rtl/fpu_op_sequencer.sv
// Single-issue sequencer between a valid/ready request port and the hardfloat datapath:
// loads operand registers, waits LATENCY cycles, captures result/flags and hands them downstream.
module fpu_op_sequencer #(
   parameter int SIZE    = 32,
   parameter int OP_W    = 4,
   parameter int LATENCY = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] in_op,
   input  logic [SIZE:0]   in_a,
   input  logic [SIZE:0]   in_b,
   input  logic            kill,
   output logic            reg_we,
   output logic [SIZE:0]   reg_a,
   output logic [SIZE:0]   reg_b,
   output logic [OP_W-1:0] reg_op,
   input  logic [SIZE:0]   fpu_result,
   input  logic [4:0]      fpu_flags,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE:0]   out_result,
   output logic [4:0]      out_flags,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      EXEC = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [SIZE:0]   reg_a_q, reg_a_d;
   logic [SIZE:0]   reg_b_q, reg_b_d;
   logic [OP_W-1:0] reg_op_q, reg_op_d;
   logic [SIZE:0]   res_q, res_d;
   logic [4:0]      flags_q, flags_d;

   // State, counter and data registers; reset discards any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         reg_a_q  <= '0;
         reg_b_q  <= '0;
         reg_op_q <= '0;
         res_q    <= '0;
         flags_q  <= 5'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reg_a_q  <= reg_a_d;
         reg_b_q  <= reg_b_d;
         reg_op_q <= reg_op_d;
         res_q    <= res_d;
         flags_q  <= flags_d;
      end
   end

   // Next-state logic; kill only acts in LOAD and EXEC so a produced result is always delivered.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reg_a_d  = reg_a_q;
      reg_b_d  = reg_b_q;
      reg_op_d = reg_op_q;
      res_d    = res_q;
      flags_d  = flags_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               reg_a_d  = in_a;
               reg_b_d  = in_b;
               reg_op_d = in_op;
               state_d  = LOAD;
            end else begin
               state_d  = IDLE;
            end
         end
         LOAD: begin
            if (kill) begin
               state_d = IDLE;
            end else begin
               cnt_d   = LAT_M1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (kill) begin
               state_d = IDLE;
            end else if (cnt_q == 8'd0) begin
               res_d   = fpu_result;
               flags_d = fpu_flags;
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q - 8'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // in_ready is masked by rst so every output reads 0 while reset is held.
   assign in_ready   = (state_q == IDLE) && !rst;
   assign reg_we     = (state_q == LOAD);
   assign out_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign reg_a      = reg_a_q;
   assign reg_b      = reg_b_q;
   assign reg_op     = reg_op_q;
   assign out_result = res_q;
   assign out_flags  = flags_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed scoreboard bench for fpu_op_sequencer: one instance at LATENCY 2, one at LATENCY 1,
// sharing stimulus; sel picks which instance is being observed.
module tb_fpu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_op;
   logic [32:0] in_a, in_b;
   logic        kill;
   logic [32:0] fpu_result;
   logic [4:0]  fpu_flags;
   logic        out_ready;

   logic        in_ready_2, reg_we_2, out_valid_2, busy_2;
   logic [32:0] reg_a_2, reg_b_2, out_result_2;
   logic [3:0]  reg_op_2;
   logic [4:0]  out_flags_2;
   logic        in_ready_1, reg_we_1, out_valid_1, busy_1;
   logic [32:0] reg_a_1, reg_b_1, out_result_1;
   logic [3:0]  reg_op_1;
   logic [4:0]  out_flags_1;

   logic        sel = 1'b0;
   logic        m_in_ready, m_reg_we, m_out_valid, m_busy;
   logic [32:0] m_reg_a, m_reg_b, m_out_result;
   logic [3:0]  m_reg_op;
   logic [4:0]  m_out_flags;

   int          vectors = 0;
   int          miscompares = 0;
   int          we_cnt = 0;
   logic [37:0] sb[$];
   logic [37:0] exp_e;

   always #5 clk = ~clk;

   fpu_op_sequencer #(.SIZE(32), .OP_W(4), .LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .kill(kill), .reg_we(reg_we_2), .reg_a(reg_a_2),
      .reg_b(reg_b_2), .reg_op(reg_op_2), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
      .out_valid(out_valid_2), .out_ready(out_ready), .out_result(out_result_2),
      .out_flags(out_flags_2), .busy(busy_2));

   fpu_op_sequencer #(.SIZE(32), .OP_W(4), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .kill(kill), .reg_we(reg_we_1), .reg_a(reg_a_1),
      .reg_b(reg_b_1), .reg_op(reg_op_1), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
      .out_valid(out_valid_1), .out_ready(out_ready), .out_result(out_result_1),
      .out_flags(out_flags_1), .busy(busy_1));

   assign m_in_ready   = sel ? in_ready_1   : in_ready_2;
   assign m_reg_we     = sel ? reg_we_1     : reg_we_2;
   assign m_out_valid  = sel ? out_valid_1  : out_valid_2;
   assign m_busy       = sel ? busy_1       : busy_2;
   assign m_reg_a      = sel ? reg_a_1      : reg_a_2;
   assign m_reg_b      = sel ? reg_b_1      : reg_b_2;
   assign m_reg_op     = sel ? reg_op_1     : reg_op_2;
   assign m_out_result = sel ? out_result_1 : out_result_2;
   assign m_out_flags  = sel ? out_flags_1  : out_flags_2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Observes the current cycle (output transfer, reg_we pulse, ready/valid exclusion), then advances one edge.
   task automatic tick();
      chk("ready_valid_excl", 64'(m_in_ready & m_out_valid), 64'd0);
      if (m_reg_we) we_cnt++;
      if (m_out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
         end else begin
            exp_e = sb.pop_front();
            chk("out_result", 64'(m_out_result), 64'(exp_e[37:5]));
            chk("out_flags", 64'(m_out_flags), 64'(exp_e[4:0]));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int max_cycles);
      for (int i = 0; i < max_cycles && !m_out_valid; i++) tick();
      chk("wait_out_valid", 64'(m_out_valid), 64'd1);
   endtask

   task automatic req(input logic [3:0] op, input logic [32:0] a, input logic [32:0] b,
                      input logic [32:0] r, input logic [4:0] f, input bit push);
      in_valid   = 1'b1;
      in_op      = op;
      in_a       = a;
      in_b       = b;
      fpu_result = r;
      fpu_flags  = f;
      if (push) sb.push_back({r, f});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_a = 33'h0; in_b = 33'h0;
      kill = 1'b0; fpu_result = 33'h0; fpu_flags = 5'h0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(m_in_ready), 64'd0);
      chk("rst_busy", 64'(m_busy), 64'd0);
      chk("rst_out_valid", 64'(m_out_valid), 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(m_in_ready), 64'd1);
      tick();

      // Basic operation at LATENCY 2
      req(4'h1, 33'h0_3F80_0000, 33'h0_4000_0000, 33'h0_4040_0000, 5'b00001, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("load_reg_we", 64'(m_reg_we), 64'd1);
      chk("load_reg_a", 64'(m_reg_a), 64'h0_3F80_0000);
      chk("load_reg_b", 64'(m_reg_b), 64'h0_4000_0000);
      chk("load_reg_op", 64'(m_reg_op), 64'h1);
      chk("load_busy", 64'(m_busy), 64'd1);
      chk("load_in_ready", 64'(m_in_ready), 64'd0);
      tick();
      chk("exec1_reg_we", 64'(m_reg_we), 64'd0);
      chk("exec1_out_valid", 64'(m_out_valid), 64'd0);
      tick();
      chk("exec2_out_valid", 64'(m_out_valid), 64'd0);
      tick();
      chk("done_out_valid", 64'(m_out_valid), 64'd1);
      tick();
      chk("after_hs_out_valid", 64'(m_out_valid), 64'd0);
      chk("after_hs_in_ready", 64'(m_in_ready), 64'd1);

      // Back-pressure with a toggling datapath result
      out_ready = 1'b0;
      req(4'h2, 33'h1_2345_6789, 33'h0_0BAD_F00D, 33'h0_7654_3210, 5'b10000, 1'b1);
      tick();
      in_valid = 1'b0;
      wait_valid(8);
      for (int i = 0; i < 6; i++) begin
         fpu_result = ~fpu_result;
         fpu_flags  = ~fpu_flags;
         tick();
         chk("bp_out_result", 64'(m_out_result), 64'h0_7654_3210);
         chk("bp_out_flags", 64'(m_out_flags), 64'h10);
         chk("bp_out_valid", 64'(m_out_valid), 64'd1);
         chk("bp_in_ready", 64'(m_in_ready), 64'd0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_single_xfer", 64'(m_out_valid), 64'd0);
      chk("bp_sb_empty", 64'(sb.size()), 64'd0);
      chk("bp_reg_a_held", 64'(m_reg_a), 64'h1_2345_6789);

      // Kill in EXEC while counter = 1
      req(4'h3, 33'h0_1111_1111, 33'h0_2222_2222, 33'h1_DEAD_BEEF, 5'b01000, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      chk("kill_busy", 64'(m_busy), 64'd0);
      chk("kill_in_ready", 64'(m_in_ready), 64'd1);
      chk("kill_out_result", 64'(m_out_result), 64'h0_7654_3210);
      chk("kill_out_flags", 64'(m_out_flags), 64'h10);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("kill_no_valid", 64'(m_out_valid), 64'd0);
      end
      req(4'h4, 33'h0_3333_3333, 33'h0_4444_4444, 33'h0_5555_5555, 5'b00100, 1'b1);
      tick();
      in_valid = 1'b0;
      wait_valid(8);
      tick();

      // Kill in IDLE (with the request) and in DONE has no effect
      kill = 1'b1;
      out_ready = 1'b0;
      req(4'h5, 33'h0_6666_6666, 33'h0_7777_7777, 33'h0_0ACE_0ACE, 5'b00010, 1'b1);
      tick();
      in_valid = 1'b0;
      kill = 1'b0;
      chk("idle_kill_accept", 64'(m_reg_we), 64'd1);
      wait_valid(8);
      kill = 1'b1;
      tick();
      tick();
      chk("done_kill_valid", 64'(m_out_valid), 64'd1);
      kill = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("done_kill_sb", 64'(sb.size()), 64'd0);

      // Asynchronous reset between edges while a result is pending
      out_ready = 1'b0;
      req(4'h6, 33'h0_0F0F_0F0F, 33'h0_F0F0_F0F0, 33'h0_1357_9BDF, 5'b00011, 1'b0);
      tick();
      in_valid = 1'b0;
      wait_valid(8);
      rst = 1'b1;
      #2;
      chk("arst_out_valid", 64'(m_out_valid), 64'd0);
      chk("arst_busy", 64'(m_busy), 64'd0);
      chk("arst_reg_we", 64'(m_reg_we), 64'd0);
      chk("arst_in_ready", 64'(m_in_ready), 64'd0);
      chk("arst_reg_a", 64'(m_reg_a), 64'd0);
      chk("arst_reg_op", 64'(m_reg_op), 64'd0);
      chk("arst_out_result", 64'(m_out_result), 64'd0);
      chk("arst_out_flags", 64'(m_out_flags), 64'd0);
      rst = 1'b0;
      #1;
      chk("arst_release_ready", 64'(m_in_ready), 64'd1);
      out_ready = 1'b1;
      tick();

      // Back-to-back at LATENCY 1 with out_ready high
      sel = 1'b1;
      #1;
      we_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         chk("b2b_in_ready", 64'(m_in_ready), 64'd1);
         req(4'(i + 8), 33'(i * 16), 33'(i * 32), 33'(32'hA000_0000 + i), 5'(i + 1), 1'b1);
         tick();
         in_valid = 1'b0;
         chk("b2b_reg_we", 64'(m_reg_we), 64'd1);
         tick();
         chk("b2b_exec_valid", 64'(m_out_valid), 64'd0);
         tick();
         chk("b2b_done_valid", 64'(m_out_valid), 64'd1);
         tick();
      end
      chk("b2b_we_pulses", 64'(we_cnt), 64'd3);
      chk("b2b_sb_empty", 64'(sb.size()), 64'd0);

      // Reset during the second operation's EXEC at LATENCY 1
      req(4'h9, 33'h0_1000_0001, 33'h0_2000_0002, 33'h0_3000_0003, 5'b00101, 1'b1);
      tick();
      in_valid = 1'b0;
      wait_valid(6);
      tick();
      req(4'hA, 33'h0_4000_0004, 33'h0_5000_0005, 33'h0_6000_0006, 5'b01010, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rst_exec_no_valid", 64'(m_out_valid), 64'd0);
         tick();
      end
      req(4'hB, 33'h0_7000_0007, 33'h0_8000_0008, 33'h0_9000_0009, 5'b11111, 1'b1);
      tick();
      in_valid = 1'b0;
      wait_valid(6);
      tick();
      chk("restart_sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
